// File: rtl/keypad_pin_entry.sv
// Keypad front-end: collects two BCD digits, commits them to x_out on ENTER.
// Optional idle timeout for partial entries is compiled in with KEYPAD_TIMEOUT_EN.
module keypad_pin_entry #(
    parameter int unsigned TIMEOUT_CYCLES = 50
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] key_code,
    input  logic       key_valid,
    output logic [7:0] x_out,
    output logic       pin_valid,
    output logic [1:0] digit_count,
    output logic       err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ONE  = 2'd1,
        ST_TWO  = 2'd2
    } state_e;

    localparam logic [3:0] KEY_DIGIT_MAX = 4'h9;
    localparam logic [3:0] KEY_CLEAR     = 4'hA;
    localparam logic [3:0] KEY_ENTER     = 4'hB;

    // Elaboration-time guard on the timeout range
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("keypad_pin_entry: TIMEOUT_CYCLES out of range 2..65535");
    end

    state_e     state_q, state_d;
    logic [7:0] buf_q, buf_d;
    logic [7:0] x_out_q, x_out_d;
    logic       pin_valid_q, pin_valid_d;
    logic       err_q, err_d;

`ifdef KEYPAD_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] idle_cnt_q, idle_cnt_d;
`endif

    // Next-state and output decode
    always_comb begin
        state_d     = state_q;
        buf_d       = buf_q;
        x_out_d     = x_out_q;
        pin_valid_d = 1'b0;
        err_d       = 1'b0;

        if (key_valid) begin
            if (key_code <= KEY_DIGIT_MAX) begin
                case (state_q)
                    ST_IDLE: begin
                        buf_d[7:4] = key_code;
                        state_d    = ST_ONE;
                    end
                    ST_ONE: begin
                        buf_d[3:0] = key_code;
                        state_d    = ST_TWO;
                    end
                    ST_TWO:  err_d   = 1'b1;
                    default: state_d = ST_IDLE;
                endcase
            end else if (key_code == KEY_CLEAR) begin
                state_d = ST_IDLE;
                buf_d   = 8'h00;
            end else if (key_code == KEY_ENTER) begin
                if (state_q == ST_TWO) begin
                    x_out_d     = buf_q;
                    pin_valid_d = 1'b1;
                    buf_d       = 8'h00;
                    state_d     = ST_IDLE;
                end else begin
                    err_d = 1'b1;
                end
            end else begin
                err_d = 1'b1;
            end
        end

`ifdef KEYPAD_TIMEOUT_EN
        // Counter runs only while a partial entry sits idle; any key clears it
        idle_cnt_d = 16'd0;
        if (state_q != ST_IDLE && !key_valid) begin
            if (idle_cnt_q == TIMEOUT_LAST) begin
                state_d = ST_IDLE;
                buf_d   = 8'h00;
                err_d   = 1'b1;
            end else begin
                idle_cnt_d = idle_cnt_q + 16'd1;
            end
        end
`endif
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            buf_q       <= 8'h00;
            x_out_q     <= 8'h00;
            pin_valid_q <= 1'b0;
            err_q       <= 1'b0;
`ifdef KEYPAD_TIMEOUT_EN
            idle_cnt_q  <= 16'd0;
`endif
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            x_out_q     <= x_out_d;
            pin_valid_q <= pin_valid_d;
            err_q       <= err_d;
`ifdef KEYPAD_TIMEOUT_EN
            idle_cnt_q  <= idle_cnt_d;
`endif
        end
    end

    assign x_out       = x_out_q;
    assign pin_valid   = pin_valid_q;
    assign err         = err_q;
    assign digit_count = 2'(state_q);

endmodule

// File: tb/tb_keypad_pin_entry.sv
// Directed bench for keypad_pin_entry; timeout expectations follow KEYPAD_TIMEOUT_EN.
module tb_keypad_pin_entry;

    logic       clock;
    logic       reset;
    logic [3:0] key_code;
    logic       key_valid;
    logic [7:0] x_out;
    logic       pin_valid;
    logic [1:0] digit_count;
    logic       err;

    int n_cmp = 0;
    int n_err = 0;

    keypad_pin_entry #(.TIMEOUT_CYCLES(50)) dut (
        .clock       (clock),
        .reset       (reset),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .x_out       (x_out),
        .pin_valid   (pin_valid),
        .digit_count (digit_count),
        .err         (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [1:0] dc, input logic [7:0] x,
                           input logic pv, input logic er);
        check({tag, ".dc"},  8'(digit_count), 8'(dc));
        check({tag, ".x"},   x_out, x);
        check({tag, ".pv"},  8'(pin_valid), 8'(pv));
        check({tag, ".err"}, 8'(err), 8'(er));
    endtask

    // Drive one key for one cycle; returns at the following negedge
    task automatic key(input logic [3:0] code);
        key_code  = code;
        key_valid = 1'b1;
        @(negedge clock);
        key_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clock);
    endtask

    initial begin
        reset     = 1'b0;
        key_code  = 4'h0;
        key_valid = 1'b0;
        idle(2);
        chk_all("reset", 2'd0, 8'h00, 1'b0, 1'b0);
        reset = 1'b1;
        idle(1);

        // 8, 0, ENTER
        key(4'h8); chk_all("t1_k8", 2'd1, 8'h00, 1'b0, 1'b0);
        key(4'h0); chk_all("t1_k0", 2'd2, 8'h00, 1'b0, 1'b0);
        key(4'hB); chk_all("t1_ent", 2'd0, 8'h80, 1'b1, 1'b0);
        idle(1);   chk_all("t1_after", 2'd0, 8'h80, 1'b0, 1'b0);

        // 0, 3, CLEAR, 2, 9, ENTER
        key(4'h0); key(4'h3);
        chk_all("t2_two", 2'd2, 8'h80, 1'b0, 1'b0);
        key(4'hA); chk_all("t2_clr", 2'd0, 8'h80, 1'b0, 1'b0);
        key(4'h2); key(4'h9);
        chk_all("t2_29", 2'd2, 8'h80, 1'b0, 1'b0);
        key(4'hB); chk_all("t2_ent", 2'd0, 8'h29, 1'b1, 1'b0);
        idle(1);   chk_all("t2_after", 2'd0, 8'h29, 1'b0, 1'b0);

        // ENTER with one digit, then invalid code
        key(4'h1); chk_all("t3_k1", 2'd1, 8'h29, 1'b0, 1'b0);
        key(4'hB); chk_all("t3_ent1", 2'd1, 8'h29, 1'b0, 1'b1);
        key(4'hE); chk_all("t3_inv", 2'd1, 8'h29, 1'b0, 1'b1);
        idle(1);   chk_all("t3_after", 2'd1, 8'h29, 1'b0, 1'b0);
        key(4'hA); chk_all("t3_clr", 2'd0, 8'h29, 1'b0, 1'b0);

        // Third digit rejected, buffer keeps 9,2
        key(4'h9); key(4'h2);
        key(4'h7); chk_all("t4_k7", 2'd2, 8'h29, 1'b0, 1'b1);
        key(4'hB); chk_all("t4_ent", 2'd0, 8'h92, 1'b1, 1'b0);

        // ENTER then a digit on the very next cycle
        key(4'h4); key(4'h5);
        key(4'hB); chk_all("t5_ent", 2'd0, 8'h45, 1'b1, 1'b0);
        key(4'h6); chk_all("t5_next", 2'd1, 8'h45, 1'b0, 1'b0);
        key(4'hB); key(4'h3);
        key(4'hB); chk_all("t5_ent2", 2'd0, 8'h63, 1'b1, 1'b0);

        // Idle timeout on a partial entry
        key(4'h5);
        idle(49);  chk_all("to_49", 2'd1, 8'h63, 1'b0, 1'b0);
        idle(1);
`ifdef KEYPAD_TIMEOUT_EN
        chk_all("to_50", 2'd0, 8'h63, 1'b0, 1'b1);
`else
        chk_all("to_50", 2'd1, 8'h63, 1'b0, 1'b0);
`endif
        idle(1);
`ifdef KEYPAD_TIMEOUT_EN
        chk_all("to_51", 2'd0, 8'h63, 1'b0, 1'b0);
`else
        chk_all("to_51", 2'd1, 8'h63, 1'b0, 1'b0);
`endif

        // Key on the expiry cycle wins
        key(4'hA);
        key(4'h5);
        idle(49);
        key(4'h6); chk_all("to_keywin", 2'd2, 8'h63, 1'b0, 1'b0);
        key(4'hB); chk_all("to_ent", 2'd0, 8'h56, 1'b1, 1'b0);

        // Asynchronous reset mid-entry
        key(4'h4); key(4'h2);
        #2 reset = 1'b0;
        #1 chk_all("arst", 2'd0, 8'h00, 1'b0, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        idle(1);
        key(4'h0); key(4'h3);
        key(4'hB); chk_all("post_rst", 2'd0, 8'h03, 1'b1, 1'b0);
        idle(1);   chk_all("post_idle", 2'd0, 8'h03, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
